// File: rtl/seg4_scan_if.sv
// seg4_scan_if: text window in, anode/segment drive out, for the 4-digit scanner.
interface seg4_scan_if;
    logic [19:0] data;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
    modport master (input data, output an, seg, dp, frame_tick);
    modport slave  (output data, input an, seg, dp, frame_tick);
endinterface

// File: rtl/seg4_scan.sv
// seg4_scan: 4-digit common-anode 7-segment scanner with per-frame snapshot and inter-digit blanking.
module seg4_scan #(
    parameter int SCAN_DIV  = 25000,
    parameter int BLANK_CYC = 500
) (
    input logic        clk,
    input logic        rst,
    seg4_scan_if.master bus
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [19:0]   snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          tick_q, wrap, load, blank;
    logic [4:0]    code;

    function automatic logic [6:0] font(input logic [4:0] c);
        case (c)
            5'd0:  font = 7'h40;
            5'd1:  font = 7'h79;
            5'd2:  font = 7'h24;
            5'd3:  font = 7'h30;
            5'd4:  font = 7'h19;
            5'd5:  font = 7'h12;
            5'd6:  font = 7'h02;
            5'd7:  font = 7'h78;
            5'd8:  font = 7'h00;
            5'd9:  font = 7'h10;
            5'd10: font = 7'h08;
            5'd11: font = 7'h03;
            5'd12: font = 7'h46;
            5'd13: font = 7'h21;
            5'd14: font = 7'h06;
            5'd15: font = 7'h0E;
            5'd16: font = 7'h42;
            5'd17: font = 7'h09;
            5'd18: font = 7'h79;
            5'd19: font = 7'h61;
            5'd20: font = 7'h09;
            5'd21: font = 7'h47;
            5'd22: font = 7'h48;
            5'd23: font = 7'h2B;
            5'd24: font = 7'h23;
            5'd25: font = 7'h0C;
            5'd26: font = 7'h18;
            5'd27: font = 7'h2F;
            5'd28: font = 7'h12;
            5'd29: font = 7'h07;
            5'd30: font = 7'h41;
            default: font = 7'h7F;
        endcase
    endfunction

    // Digits run 3->2->1->0; the snapshot is taken only on the wrap back into slot 3.
    always_comb begin
        wrap   = cnt_q == LAST;
        load   = wrap && dig_q == 2'd0;
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        dig_d  = wrap ? dig_q - 2'd1 : dig_q;
        snap_d = load ? bus.data : snap_q;
        code   = snap_q[5*dig_q +: 5];
        blank  = BLANK_CYC > 0 && int'(cnt_q) < BLANK_CYC;
        an_d   = blank ? 4'hF : ~(4'b0001 << dig_q);
        seg_d  = blank ? 7'h7F : font(code);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= LAST;
            dig_q  <= 2'd0;
            snap_q <= '1;
            an_q   <= 4'hF;
            seg_q  <= 7'h7F;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            tick_q <= load;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg4_scan.sv
// tb_seg4_scan: directed checks of scan order, blanking, snapshot, glyph ROM and reset for seg4_scan.
module tb_seg4_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg4_scan_if ia();
    seg4_scan_if ib();

    seg4_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut_a (.clk(clk), .rst(rst), .bus(ia.master));
    seg4_scan #(.SCAN_DIV(4), .BLANK_CYC(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.master));

    int n_chk = 0;
    int n_fail = 0;
    int k = 0;

    logic [19:0] old_a = {5'd12, 5'd10, 5'd18, 5'd12};
    logic [6:0] seg_old [4] = '{7'h46, 7'h79, 7'h08, 7'h46};
    logic [6:0] seg_b [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [6:0] rom [32] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                             7'h42, 7'h09, 7'h79, 7'h61, 7'h09, 7'h47, 7'h48, 7'h2B,
                             7'h23, 7'h0C, 7'h18, 7'h2F, 7'h12, 7'h07, 7'h41, 7'h7F};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    initial begin
        ia.data = old_a;
        ib.data = {5'd1, 5'd2, 5'd3, 5'd4};
        repeat (3) step();
        chk("rst_an_a", ia.an, 4'hF);
        chk("rst_seg_a", ia.seg, 7'h7F);
        chk("rst_tick_a", ia.frame_tick, 1'b0);
        chk("rst_dp_a", ia.dp, 1'b1);
        chk("rst_an_b", ib.an, 4'hF);
        rst = 1'b0;
        k = 0;
        // Eight frames of A with a mid-frame data change; B checked for gapless stepping.
        for (int i = 0; i < 259; i++) begin
            step();
            if (k == 204) ia.data = 20'h00000;
            chk("frame_tick", ia.frame_tick, k % 32 == 1);
            chk("dp", ia.dp, 1'b1);
            if (k >= 2) begin
                int c, d, db;
                logic bl;
                c = (k - 2) % 32;
                d = 3 - c / 8;
                bl = c % 8 < 2;
                chk("an_a", ia.an, bl ? 4'hF : 4'hF & ~(4'd1 << d));
                chk("seg_a", ia.seg, bl ? 7'h7F : ((k - 2) / 32 >= 7 ? 7'h40 : seg_old[d]));
                db = 3 - ((k - 2) / 4) % 4;
                chk("an_b", ib.an, 4'hF & ~(4'd1 << db));
                chk("seg_b", ib.seg, seg_b[db]);
            end
        end
        for (int code = 0; code < 32; code++) begin
            while (k % 32 != 0) step();
            ia.data = {5'(code), 15'h7FFF};
            repeat (4) step();
            chk("rom_seg", ia.seg, rom[code]);
            chk("rom_an", ia.an, 4'b0111);
        end
        while (k % 32 != 22) step();
        chk("pre_rst_an", ia.an, 4'b1101);
        rst = 1'b1;
        step();
        chk("mid_rst_an", ia.an, 4'hF);
        chk("mid_rst_seg", ia.seg, 7'h7F);
        chk("mid_rst_tick", ia.frame_tick, 1'b0);
        chk("mid_rst_dp", ia.dp, 1'b1);
        repeat (2) step();
        rst = 1'b0;
        ia.data = old_a;
        k = 0;
        step();
        chk("restart_tick", ia.frame_tick, 1'b1);
        step();
        chk("restart_tick_off", ia.frame_tick, 1'b0);
        chk("restart_blank", ia.an, 4'hF);
        repeat (2) step();
        chk("restart_an", ia.an, 4'b0111);
        chk("restart_seg", ia.seg, 7'h46);
        chk("restart_dp", ia.dp, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
